// File: rtl/serial_pkg.sv
// Shared serial-line definitions: FSM encoding, line levels and parameter defaults.
// The PARITY state exists only when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

   localparam int unsigned CLK_DIV_DEF = 4;
   localparam int unsigned DATA_W_DEF  = 8;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts CLK_DIV cycles per bit and flags the final cycle of each bit.
// bit_end is registered and high during the last cycle of the current bit.
module serial_bit_timer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
   localparam logic ONE_CYC = (CLK_DIV == 1);

   logic [CNT_W-1:0] cnt_q;

   // Counter restarts on clear or at the end of every bit, so each bit starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         bit_end <= 1'b0;
      end else if (clear || bit_end) begin
         cnt_q   <= '0;
         bit_end <= ONE_CYC;
      end else begin
         cnt_q   <= cnt_q + CNT_W'(1);
         bit_end <= ((cnt_q + CNT_W'(1)) == LAST);
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Even parity bit is inserted when SERIAL_TX_PARITY_EN is defined.
module serial_tx
   import serial_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              load,
   output logic              ready,
   output logic              busy,
   output logic              txd,
   output logic              done
);

   localparam int unsigned IDX_W = $clog2(DATA_W + 2);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic                txd_q, txd_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                bit_end;
   logic                timer_clear_c;
`ifdef SERIAL_TX_PARITY_EN
   logic                par_q, par_d;
`endif

   assign timer_clear_c = (state_q == IDLE);

   serial_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear_c),
      .bit_end (bit_end)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txd_q     <= IDLE_LEVEL;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Next-state and next-output logic; txd_d is the level of the bit that starts at this edge
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      txd_d     = txd_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_d     = par_q;
`endif

      unique case (state_q)
         IDLE: begin
            txd_d   = IDLE_LEVEL;
            ready_d = 1'b1;
            if (load) begin
               state_d   = START;
               shift_d   = din;
               bit_idx_d = '0;
               txd_d     = START_LEVEL;
               ready_d   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
               par_d     = 1'b0;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               txd_d     = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
               par_d     = shift_q[0];
`endif
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = PARITY;
                  txd_d   = par_q;
`else
                  state_d = STOP;
                  txd_d   = IDLE_LEVEL;
`endif
               end else begin
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + IDX_W'(1);
`ifdef SERIAL_TX_PARITY_EN
                  par_d     = par_q ^ shift_q[0];
`endif
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               txd_d   = IDLE_LEVEL;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               txd_d   = IDLE_LEVEL;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = IDLE_LEVEL;
            ready_d = 1'b1;
         end
      endcase

      busy_d = ~ready_d;
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign txd   = txd_q;
   assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx against a per-cycle frame model (CLK_DIV=4 and CLK_DIV=1 instances).
// Parity expectations follow SERIAL_TX_PARITY_EN.
module tb_serial_tx;

   localparam int W  = 8;
   localparam int CD = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NB = W + 3;
`else
   localparam int NB = W + 2;
`endif
   localparam int N  = NB * CD;
   localparam int N1 = NB;

   logic clk = 1'b0;
   logic rst_n;
   logic load, load1;
   logic [7:0] din, din1;
   logic ready, busy, txd, done;
   logic ready1, busy1, txd1, done1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_tx #(.CLK_DIV(CD), .DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .load(load),
      .ready(ready), .busy(busy), .txd(txd), .done(done)
   );

   serial_tx #(.CLK_DIV(1), .DATA_W(W)) dut1 (
      .clk(clk), .rst_n(rst_n), .din(din1), .load(load1),
      .ready(ready1), .busy(busy1), .txd(txd1), .done(done1)
   );

   // Line level of bit b of a frame carrying d
   function automatic logic exp_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= W) return d[b-1];
`ifdef SERIAL_TX_PARITY_EN
      if (b == W + 1) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int k, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%b exp=%b", name, k, got, exp);
      end
   endtask

   // Sends d and checks every cycle up to and including the DONE cycle.
   task automatic run_frame(input logic [7:0] d, input int noise_at, input logic [7:0] noise_d,
                            input bit chain, input logic [7:0] chain_d);
      logic et, er;
      din  = d;
      load = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= N; k++) begin
         @(negedge clk);
         et = (k < N) ? exp_bit(d, k / CD) : 1'b1;
         er = (k == N);
         chk("txd", k, txd, et);
         chk("ready", k, ready, er);
         chk("busy", k, busy, ~er);
         chk("done", k, done, er);
         if (chain) begin
            load = 1'b1;
            din  = chain_d;
         end else if (k == noise_at) begin
            load = 1'b1;
            din  = noise_d;
         end else begin
            load = 1'b0;
            din  = 8'($urandom);
         end
      end
      if (!chain) begin
         @(negedge clk);
         chk("done_clear", N + 1, done, 1'b0);
         chk("idle_ready", N + 1, ready, 1'b1);
         chk("idle_txd", N + 1, txd, 1'b1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load  = 1'b1;
      din   = 8'hFF;
      load1 = 1'b1;
      din1  = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_txd", 0, txd, 1'b1);
      chk("rst_ready", 0, ready, 1'b1);
      chk("rst_busy", 0, busy, 1'b0);
      chk("rst_done", 0, done, 1'b0);
      chk("rst_txd1", 0, txd1, 1'b1);
      chk("rst_ready1", 0, ready1, 1'b1);
      rst_n = 1'b1;
      load  = 1'b0;
      load1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_ready", 1, ready, 1'b1);
      chk("post_rst_txd", 1, txd, 1'b1);
   endtask

   task automatic test_frame_a5();
      run_frame(8'hA5, -1, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_parity_07();
      run_frame(8'h07, -1, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_ignore_load();
      run_frame(8'hA5, 12, 8'h3C, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      run_frame(8'h00, -1, 8'h00, 1'b1, 8'hFF);
      run_frame(8'hFF, -1, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_frame(8'($urandom), int'($urandom_range(1, N - 3)), 8'($urandom), 1'b0, 8'h00);
      end
   endtask

   task automatic test_reset_mid();
      din  = 8'hA5;
      load = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         load = 1'b0;
         if (k < 17) chk("pre_rst_txd", k, txd, exp_bit(8'hA5, k / CD));
      end
      rst_n = 1'b0;
      #1;
      chk("async_txd", 17, txd, 1'b1);
      chk("async_ready", 17, ready, 1'b1);
      chk("async_busy", 17, busy, 1'b0);
      chk("async_done", 17, done, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_hold_done", k, done, 1'b0);
      end
      rst_n = 1'b1;
      run_frame(8'h5A, -1, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_div1();
      logic et, er;
      din1  = 8'h81;
      load1 = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= N1; k++) begin
         @(negedge clk);
         load1 = 1'b0;
         din1  = 8'($urandom);
         et = (k < N1) ? exp_bit(8'h81, k) : 1'b1;
         er = (k == N1);
         chk("div1_txd", k, txd1, et);
         chk("div1_ready", k, ready1, er);
         chk("div1_busy", k, busy1, ~er);
         chk("div1_done", k, done1, er);
      end
      @(negedge clk);
      chk("div1_done_clear", N1 + 1, done1, 1'b0);
   endtask

   initial begin
      load  = 1'b0;
      load1 = 1'b0;
      din   = '0;
      din1  = '0;
      rst_n = 1'b0;
      test_reset();
      test_frame_a5();
      test_parity_07();
      test_ignore_load();
      test_back_to_back();
      test_reset_mid();
      test_div1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: CLK cycles per serial bit; legal range 1..255.
REQ-002 Parameter DATA_W, default 8: payload bits per frame; legal range 5..9.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 DIN  input  DATA_W  parallel payload; sampled only on the accept edge.
REQ-006 LOAD  input  1  frame request; accepted when LOAD=1 and READY=1 at a rising edge.
REQ-007 READY  output  1  high when idle and able to accept a frame.
REQ-008 BUSY  output  1  high while a frame is on TXD; always equal to ~READY.
REQ-009 TXD  output  1  registered serial line; idle level 1.
REQ-010 DONE  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (only when enabled) and STOP.
REQ-012 Accept edge E0: DIN latched into a shift register, FSM IDLE->START, TXD=0 from E0, READY=0.
REQ-013 Every bit SHALL hold TXD for exactly CLK_DIV cycles, timed by a bit-cycle counter cleared on every bit change.
REQ-014 START->DATA after CLK_DIV cycles; DATA sends DIN LSB first, DATA_W bits.
REQ-015 After the last data bit: DATA->PARITY when enabled, otherwise DATA->STOP; STOP drives TXD=1 for CLK_DIV cycles.
REQ-016 Frame length N = (2+DATA_W)*CLK_DIV cycles, plus CLK_DIV with parity; STOP->IDLE at edge E0+N.
REQ-017 At E0+N: READY=1 and DONE=1 for exactly one cycle; TXD stays 1.
REQ-018 LOAD=1 during the DONE cycle SHALL be accepted at the next edge (E0+N+1), giving a one-cycle idle gap between frames.
REQ-019 LOAD while READY=0 SHALL be ignored, without queueing; DIN changes after E0 SHALL not affect the frame in flight.
REQ-020 CLK_DIV=1 SHALL work: one cycle per bit, with no counter wrap error.
REQ-021 The bit counter SHALL be wide enough for DATA_W+1 and the cycle counter wide enough for CLK_DIV-1; neither wraps within a frame.

Reset
REQ-022 RST_n=0 SHALL immediately force: FSM=IDLE, TXD=1, READY=1, BUSY=0, DONE=0, counters=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame without a DONE pulse; the first accept is possible at the first rising edge after RST_n goes high.
REQ-024 LOAD asserted during reset SHALL be ignored.

Configuration
REQ-025 Macro SERIAL_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, sending even parity (XOR of the payload) for CLK_DIV cycles.
REQ-026 Macro SERIAL_TX_PARITY_EN undefined: no PARITY state and no parity logic; frame length as in REQ-016 without the parity term.

Structure
REQ-027 The shared package serial_pkg SHALL hold the FSM state encoding, IDLE_LEVEL=1, START_LEVEL=0 and the CLK_DIV/DATA_W defaults, so a future receiver can reuse them.
REQ-028 The bit-timing counter SHALL be the sub-module serial_bit_timer (inputs CLK, RST_n, clear; output bit_end pulse).

Verification
REQ-029 CLK_DIV=4, DIN=8'hA5, LOAD pulse -> TXD = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; DONE at cycle 40, READY=1 at cycle 40.
REQ-030 With SERIAL_TX_PARITY_EN and DIN=8'h07 -> parity bit 1 after bit 7; DONE at cycle 44.
REQ-031 LOAD with 8'h3C at cycle 12 of an 8'hA5 frame -> ignored; TXD pattern identical to REQ-029; exactly one DONE.
REQ-032 8'h00, then LOAD held through DONE with 8'hFF -> second start bit at cycle 41; line = 0 for 36 cycles, 1 at cycle 40, then 0 start bit, 8 ones, stop.
REQ-033 RST_n=0 at cycle 17 of an 8'hA5 frame -> TXD=1 asynchronously, READY=1, no DONE; after release, a new 8'h5A frame transmits correctly.
REQ-034 CLK_DIV=1, DIN=8'h81 -> TXD 0,1,0,0,0,0,0,0,1,1 one cycle each; DONE at cycle 10.
